dmem_status_responder: RTL

Synthesizable data-memory-bus responder that sits beside `dmem` on the multi-cycle MCU data port and acts as the in-design counterpart of the bench-side write monitor. It answers CPU loads and stores with a wait-state handshake and decodes stores into a sticky PASS/FAIL/TIMEOUT result. It exposes that result on pins and as a readable status word, so test programs can self-check and FPGA builds can drive LEDs.

---
 rtl/dmem_status_responder_pkg.sv | 23 ++
 rtl/dmem_status_responder_bus_wait_ctr.sv | 69 ++++++
 rtl/dmem_status_responder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dmem_status_responder_pkg.sv
// Shared MCU constants for the data-memory status responder: result-state and
// bus-handshake encodings plus the default result/scratch/status addresses.
package dmem_status_responder_pkg;

  typedef enum logic [1:0] {
    RES_RUN     = 2'b00,
    RES_PASS    = 2'b01,
    RES_FAIL    = 2'b10,
    RES_TIMEOUT = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'b00,
    BUS_WAIT = 2'b01,
    BUS_ACK  = 2'b10
  } bus_state_e;

  localparam logic [31:0] DEF_PASS_ADDR    = 32'd100;
  localparam logic [31:0] DEF_PASS_DATA    = 32'd7;
  localparam logic [31:0] DEF_SCRATCH_ADDR = 32'd96;
  localparam logic [31:0] DEF_STATUS_ADDR  = 32'd104;

endpackage

// File: rtl/dmem_status_responder_bus_wait_ctr.sv
// bus_wait_ctr: wait-state handshake sequencer. A request seen in IDLE
// produces a one-cycle ACK WAIT_STATES cycles later; dropping the request
// while waiting aborts back to IDLE. Also usable for dmem latency modelling.
module bus_wait_ctr
  import dmem_status_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output bus_state_e state,
  output logic       ack,
  output logic       ack_next
);

  // The IDLE cycle that sees the request counts as the first wait state,
  // so WAIT only holds for WAIT_STATES-1 cycles.
  localparam bit         DIRECT_ACK = (WAIT_STATES <= 1);
  localparam logic [3:0] LAST_WAIT  = (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 2) : 4'd0;

  bus_state_e state_nxt;
  logic [3:0] cnt_q;
  logic [3:0] cnt_nxt;

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BUS_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Next-state: IDLE -> (WAIT ->) ACK -> IDLE, abort on dropped request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    case (state)
      BUS_IDLE: begin
        if (req) begin
          if (DIRECT_ACK) begin
            state_nxt = BUS_ACK;
          end else begin
            state_nxt = BUS_WAIT;
            cnt_nxt   = '0;
          end
        end
      end
      BUS_WAIT: begin
        if (!req) begin
          state_nxt = BUS_IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          state_nxt = BUS_ACK;
        end else begin
          cnt_nxt = cnt_q + 4'd1;
        end
      end
      BUS_ACK:  state_nxt = BUS_IDLE;
      default:  state_nxt = BUS_IDLE;
    endcase
  end

  assign ack      = (state == BUS_ACK);
  assign ack_next = (state_nxt == BUS_ACK);

endmodule

// File: rtl/dmem_status_responder.sv
// dmem_status_responder: answers CPU loads/stores on the multi-cycle data
// port and decodes committed stores into a sticky PASS/FAIL(/TIMEOUT)
// result, visible on pins and as a status word.
// Optional feature macro: STATUS_TIMEOUT_EN (RUN-state watchdog).
module dmem_status_responder
  import dmem_status_responder_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
  parameter logic [31:0] SCRATCH_ADDR   = DEF_SCRATCH_ADDR,
  parameter logic [31:0] STATUS_ADDR    = DEF_STATUS_ADDR,
  parameter int          WAIT_STATES    = 1,
  parameter int          TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        pass,
  output logic        fail,
  output logic        done,
  output logic        timeout
);

  bus_state_e  bus_state;
  logic        ack;
  logic        ack_next;
  logic        req;
  logic        is_store_q;
  logic        store_now;
  logic        commit;
  logic        wdog_expire;
  result_e     res_q;
  result_e     res_nxt;
  logic [31:0] scratch_q;
  logic [15:0] wcnt_q;
  logic [31:0] rdata_q;
  logic [31:0] load_val;

  assign req = MemWrite | MemRead;

  bus_wait_ctr #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .state    (bus_state),
    .ack      (ack),
    .ack_next (ack_next)
  );

  // Access type is captured in the cycle the request is first seen in IDLE;
  // a simultaneous MemWrite/MemRead is a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_store_q <= 1'b0;
    end else if (bus_state == BUS_IDLE) begin
      is_store_q <= MemWrite;
    end
  end

  // With one wait state the ACK follows IDLE directly, so the type is
  // still only visible on the live inputs.
  assign store_now = (bus_state == BUS_IDLE) ? MemWrite : is_store_q;
  assign commit    = ack & is_store_q;

  // Load return mux; loads never touch state.
  always_comb begin
    load_val = '0;
    if (DataAdr == STATUS_ADDR) begin
      load_val = {res_q, 14'b0, wcnt_q};
    end else if (DataAdr == SCRATCH_ADDR) begin
      load_val = scratch_q;
    end
  end

  // ReadData is registered on entry to ACK and forced to 0 otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= (ack_next && !store_now) ? load_val : '0;
    end
  end

  // Scratch register and saturating committed-store counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q <= '0;
      wcnt_q    <= '0;
    end else if (commit) begin
      if (DataAdr == SCRATCH_ADDR) begin
        scratch_q <= WriteData;
      end
      if (wcnt_q != 16'hFFFF) begin
        wcnt_q <= wcnt_q + 16'd1;
      end
    end
  end

`ifdef STATUS_TIMEOUT_EN
  logic [31:0] wdog_q;

  // Watchdog counts clk cycles in RUN and freezes once a result is decided.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
    end else if (res_q == RES_RUN) begin
      wdog_q <= wdog_q + 32'd1;
    end
  end

  assign wdog_expire = (res_q == RES_RUN) && ((wdog_q + 32'd1) == 32'(TIMEOUT_CYCLES));
  assign timeout     = (res_q == RES_TIMEOUT);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
  assign wdog_expire           = 1'b0;
  assign timeout               = 1'b0;
`endif

  // Result register: leaves RUN only, sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= RES_RUN;
    end else begin
      res_q <= res_nxt;
    end
  end

  // Result next-state: a decisive store beats a same-cycle watchdog expiry.
  always_comb begin
    res_nxt = res_q;
    if (res_q == RES_RUN) begin
      if (commit && (DataAdr == PASS_ADDR)) begin
        res_nxt = (WriteData == PASS_DATA) ? RES_PASS : RES_FAIL;
      end else if (commit && (DataAdr != SCRATCH_ADDR)) begin
        res_nxt = RES_FAIL;
      end else if (wdog_expire) begin
        res_nxt = RES_TIMEOUT;
      end
    end
  end

  assign ReadData = rdata_q;
  assign Ready    = ack;
  assign pass     = (res_q == RES_PASS);
  assign fail     = (res_q == RES_FAIL) || (res_q == RES_TIMEOUT);
  assign done     = (res_q != RES_RUN);

endmodule
